// File: rtl/bp_be_loop_prefetch_issuer.sv
// rtl/bp_be_loop_prefetch_issuer.sv - expands inferred-loop records into deduplicated block prefetches
module bp_be_loop_prefetch_issuer
  #(parameter int vaddr_width_p        = 39
  , parameter int output_range_p       = 8
  , parameter int stride_width_p       = 8
  , parameter int max_prefetch_p       = 16
  , parameter int block_offset_width_p = 6
  )
  (input  logic                      clk_i
  , input  logic                      reset_i
  , input  logic                      loop_v_i
  , input  logic [output_range_p-1:0] loop_remaining_i
  , input  logic [vaddr_width_p-1:0]  loop_pc_i
  , input  logic [vaddr_width_p-1:0]  loop_eff_addr_i
  , input  logic [stride_width_p-1:0] loop_stride_i
  , output logic                      loop_yumi_o
  , input  logic                      flush_i
  , output logic                      pf_v_o
  , output logic [vaddr_width_p-1:0]  pf_addr_o
  , output logic [vaddr_width_p-1:0]  pf_pc_o
  , input  logic                      pf_ready_and_i
  , output logic                      busy_o
  );

  localparam int blk_width_lp = vaddr_width_p - block_offset_width_p;

  typedef enum logic {e_idle, e_issue} state_e;
  state_e state_r, state_n;

  logic [vaddr_width_p-1:0]  addr_r, pc_r;
  logic [stride_width_p-1:0] stride_r;
  logic [output_range_p-1:0] count_r;
  logic [blk_width_lp-1:0]   last_blk_r;
  logic                      last_blk_v_r;

  logic                      in_issue, dup, advance, issue_fire, record_empty;
  logic [blk_width_lp-1:0]   cur_blk;
  logic [output_range_p-1:0] count_clamp;
  logic [vaddr_width_p-1:0]  loop_stride_sext, stride_sext;

  assign in_issue = (state_r == e_issue);
  assign cur_blk  = addr_r[vaddr_width_p-1:block_offset_width_p];
  assign dup      = last_blk_v_r & (cur_blk == last_blk_r);

  assign loop_yumi_o = ~in_issue & loop_v_i & ~flush_i;
  assign pf_v_o      = in_issue & ~dup & ~flush_i;
  assign pf_addr_o   = {cur_blk, {block_offset_width_p{1'b0}}};
  assign pf_pc_o     = pc_r;
  assign busy_o      = in_issue;

  assign issue_fire = pf_v_o & pf_ready_and_i;
  // A duplicate block is skipped without consulting the D$ handshake
  assign advance    = in_issue & ~flush_i & (dup | pf_ready_and_i);

  assign count_clamp  = (loop_remaining_i > output_range_p'(max_prefetch_p))
                        ? output_range_p'(max_prefetch_p) : loop_remaining_i;
  assign record_empty = (count_clamp == '0) | (loop_stride_i == '0);

  assign loop_stride_sext = {{(vaddr_width_p-stride_width_p){loop_stride_i[stride_width_p-1]}}, loop_stride_i};
  assign stride_sext      = {{(vaddr_width_p-stride_width_p){stride_r[stride_width_p-1]}}, stride_r};

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:  if (loop_yumi_o & ~record_empty) state_n = e_issue;
      e_issue: if (flush_i) state_n = e_idle;
               else if (advance & (count_r == output_range_p'(1))) state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= e_idle;
      addr_r       <= '0;
      pc_r         <= '0;
      stride_r     <= '0;
      count_r      <= '0;
      last_blk_r   <= '0;
      last_blk_v_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if (loop_yumi_o) begin
        addr_r       <= loop_eff_addr_i + loop_stride_sext;
        pc_r         <= loop_pc_i;
        stride_r     <= loop_stride_i;
        count_r      <= count_clamp;
        last_blk_v_r <= 1'b0;
      end else if (advance) begin
        addr_r  <= addr_r + stride_sext;
        count_r <= count_r - output_range_p'(1);
        if (issue_fire) begin
          last_blk_r   <= cur_blk;
          last_blk_v_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/bp_be_loop_prefetch_issuer.md
Name: bp_be_loop_prefetch_issuer

Overview:
- Sits directly downstream of the loop-inference stage in the BE checker.
- Consumes one inferred-loop record per handshake: striding-load PC, effective address, stride, and remaining iteration count.
- Expands the record into a bounded sequence of cache-block-aligned prefetch addresses and issues them one at a time to the D$ prefetch port.
- Suppresses consecutive requests that fall in the same cache block.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies vaddr_width_p.
- output_range_p, 8, width of the remaining-iteration input.
- stride_width_p, 8, width of the stride input; two's-complement signed.
- max_prefetch_p, 16, maximum iterations expanded per loop record; must be ≥1.
- block_offset_width_p, 6, log2 of cache block bytes (64 B blocks).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- loop_v_i  in  1  loop record valid
- loop_remaining_i  in  output_range_p  remaining loop iterations
- loop_pc_i  in  vaddr_width_p  striding load PC
- loop_eff_addr_i  in  vaddr_width_p  effective address of the striding load
- loop_stride_i  in  stride_width_p  signed byte stride
- loop_yumi_o  out  1  record consumed this cycle
- flush_i  in  1  abort the current expansion
- pf_v_o  out  1  prefetch request valid
- pf_addr_o  out  vaddr_width_p  block-aligned prefetch address
- pf_pc_o  out  vaddr_width_p  PC of the loop currently being expanded
- pf_ready_and_i  in  1  D$ accepts request
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Clocking and reset: one clock, clk_i. reset_i is synchronous and active-high.
  - Reset forces state IDLE; clears addr_r, count_r, pc_r, last_blk_r, last_blk_v_r.
  - After reset, all outputs are 0.
  - Reset mid-ISSUE abandons the record with no further pf_v_o.
- States: IDLE, ISSUE.
- IDLE:
  - loop_yumi_o = loop_v_i & ~flush_i (combinational).
  - On yumi, latch:
    - addr_r = loop_eff_addr_i + sext(loop_stride_i)
    - count_r = min(loop_remaining_i, max_prefetch_p)
    - pc_r = loop_pc_i
  - Also clear last_blk_v_r.
  - If count is 0 or stride is 0: the record is consumed and dropped, and state stays IDLE.
  - Otherwise go to ISSUE next cycle.
- ISSUE:
  - loop_yumi_o = 0.
  - cur_blk = addr_r[vaddr_width_p-1:block_offset_width_p].
  - dup = last_blk_v_r & (cur_blk == last_blk_r).
  - pf_v_o = ~dup & ~flush_i.
  - pf_addr_o = {cur_blk, block_offset_width_p zeros}.
  - pf_pc_o = pc_r.
  - Advance when dup, or when pf_v_o & pf_ready_and_i:
    - addr_r += sext(stride_r)
    - count_r -= 1
    - on a real issue: last_blk_r = cur_blk and last_blk_v_r = 1
    - if count_r was 1, go to IDLE
  - When neither condition holds, hold everything. pf_addr_o and pf_pc_o stay stable while pf_v_o is high and ready is low. pf_v_o is never withdrawn except by flush or reset.
  - A dup skip costs one cycle; throughput is one issue per cycle with ready held high.
- Flush: flush_i in any state forces IDLE next cycle and gates pf_v_o and loop_yumi_o low in the same cycle. Flush has priority over loop_v_i and pf_ready_and_i.
- Arithmetic: addresses wrap modulo 2^vaddr_width_p; no overflow detection. Stride is sign-extended to vaddr_width_p.
- No new record is accepted until the FSM returns to IDLE. The upstream stage holds loop_v_i until yumi.
- busy_o = (state == ISSUE).

Test Plan:
1. Same-block dedup: eff_addr 0x1000, stride 8, remaining 20, ready held high → count clamps to 16; exactly 3 requests issued (0x1000, 0x1040, 0x1080); FSM back in IDLE 17 cycles after yumi.
2. Block stride: eff_addr 0x1000, stride 0x40, remaining 3 → 0x1040, 0x1080, 0x10C0 on 3 consecutive cycles; pf_pc_o equals loop_pc_i throughout.
3. Negative stride with backpressure: eff_addr 0x2000, stride 0xC0 (−64), remaining 2, ready low 5 cycles then high → pf_addr_o holds 0x1FC0 for 6 cycles, then 0x1F80 issues.
4. Zero-length records: remaining 0 (stride 8), then stride 0 (remaining 5) → each record yumi'd in one cycle; pf_v_o never asserts; busy_o stays 0.
5. Flush mid-issue: stride 0x40, remaining 10, assert flush_i after the 3rd accepted request → pf_v_o low that cycle, IDLE next cycle, no 4th request. A pending loop_v_i is not yumi'd during flush and is accepted on the next cycle.
6. Wrap and reset: eff_addr 0x7F_FFFF_FFC0, stride 0x40, remaining 2 → 0x0 then 0x40. Assert reset_i while pf_v_o=1 and ready=0 → pf_v_o=0 on the next cycle, busy_o=0.
